// File: rtl/layer_blitter.sv
// Rectangle fill engine: one command in, one VRAM write per in-bounds pixel out,
// row-major, stalling on wr_ready. Address advances incrementally per pixel/row.
module layer_blitter #(
  parameter int DATA_WIDTH = 13,
  parameter int AWIDTH     = 15,
  parameter int LWIDTH     = 160,
  parameter int LHEIGHT    = 120,
  parameter int CWIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CWIDTH-1:0]     cmd_x,
  input  logic [CWIDTH-1:0]     cmd_y,
  input  logic [CWIDTH-1:0]     cmd_w,
  input  logic [CWIDTH-1:0]     cmd_h,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  wr_en,
  output logic [AWIDTH-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {IDLE, FILL} state_t;

  localparam logic [AWIDTH-1:0] LW_A = AWIDTH'(LWIDTH);
  localparam logic [CWIDTH:0]   LW_C = (CWIDTH+1)'(LWIDTH);
  localparam logic [CWIDTH:0]   LH_C = (CWIDTH+1)'(LHEIGHT);

  state_t              state;
  logic [CWIDTH-1:0]   x, w, h, col, row;
  logic [CWIDTH:0]     px, py;
  logic [AWIDTH-1:0]   base;

  logic [CWIDTH:0]     nxt_px, nxt_py;
  logic [AWIDTH-1:0]   nxt_base, nxt_addr;
  logic                nxt_inb, col_last, last, retire;

  assign col_last = (col == w - CWIDTH'(1));
  assign last     = col_last && (row == h - CWIDTH'(1));
  assign retire   = !wr_en || wr_ready;

  // Row base may wrap for rows past the layer; such rows never write, so the
  // truncation is harmless for every in-bounds pixel.
  always_comb begin
    nxt_px   = px;
    nxt_py   = py;
    nxt_base = base;
    if (state == IDLE) begin
      nxt_px   = {1'b0, cmd_x};
      nxt_py   = {1'b0, cmd_y};
      nxt_base = AWIDTH'(cmd_y) * LW_A;
    end else if (col_last) begin
      nxt_px   = {1'b0, x};
      nxt_py   = py + (CWIDTH+1)'(1);
      nxt_base = base + LW_A;
    end else begin
      nxt_px   = px + (CWIDTH+1)'(1);
    end
    nxt_inb  = (nxt_px < LW_C) && (nxt_py < LH_C);
    nxt_addr = nxt_base + AWIDTH'(nxt_px);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      x         <= '0;
      w         <= '0;
      h         <= '0;
      col       <= '0;
      row       <= '0;
      px        <= '0;
      py        <= '0;
      base      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            x       <= cmd_x;
            w       <= cmd_w;
            h       <= cmd_h;
            wr_data <= cmd_data;
            if (cmd_w != '0 && cmd_h != '0) begin
              state     <= FILL;
              busy      <= 1'b1;
              cmd_ready <= 1'b0;
              col       <= '0;
              row       <= '0;
              px        <= nxt_px;
              py        <= nxt_py;
              base      <= nxt_base;
              wr_en     <= nxt_inb;
              if (nxt_inb) wr_addr <= nxt_addr;
            end else begin
              done <= 1'b1;
            end
          end
        end
        FILL: begin
          if (retire) begin
            if (last) begin
              state     <= IDLE;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
              wr_en     <= 1'b0;
              done      <= 1'b1;
            end else begin
              if (col_last) begin
                col <= '0;
                row <= row + CWIDTH'(1);
              end else begin
                col <= col + CWIDTH'(1);
              end
              px    <= nxt_px;
              py    <= nxt_py;
              base  <= nxt_base;
              wr_en <= nxt_inb;
              if (nxt_inb) wr_addr <= nxt_addr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_blitter.sv
// Directed bench for layer_blitter: fill, backpressure, clipping, zero size,
// command while busy and reset mid-fill, with hand-computed expectations.
module tb_layer_blitter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_x, cmd_y, cmd_w, cmd_h;
  logic [12:0] cmd_data;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [12:0] wr_data;
  logic        wr_ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int writes = 0;

  layer_blitter #(
    .DATA_WIDTH(13), .AWIDTH(15), .LWIDTH(160), .LHEIGHT(120), .CWIDTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_data(cmd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Accepted writes and global address / busy invariants.
  always @(posedge clk) begin
    if (!rst && wr_en) begin
      if (wr_ready) writes++;
      checks++;
      assert (wr_addr < 15'd19200 && busy === 1'b1)
        else begin
          errors++;
          $error("FAIL inv_write: addr=%0d busy=%b required addr<19200 busy=1", wr_addr, busy);
        end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input int y, input int w, input int h, input int d);
    cmd_x = 8'(x); cmd_y = 8'(y); cmd_w = 8'(w); cmd_h = 8'(h);
    cmd_data = 13'(d);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input int addr, input int data);
    chk({tag, "_en"}, 32'(wr_en), 32'd1);
    chk({tag, "_addr"}, 32'(wr_addr), 32'(addr));
    chk({tag, "_data"}, 32'(wr_data), 32'(data));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic chk_done(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_wren"}, 32'(wr_en), 32'd0);
    chk({tag, "_rdy"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; wr_ready = 1'b1;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_data = '0;
    tick(); tick();
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_wren", 32'(wr_en), 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // Basic 2x2 fill at (1,1)
    writes = 0;
    send(1, 1, 2, 2, 'h1ABC);
    chk("basic_ready", 32'(cmd_ready), 32'd0);
    chk_wr("basic_p0", 161, 'h1ABC); tick();
    chk_wr("basic_p1", 162, 'h1ABC); tick();
    chk_wr("basic_p2", 321, 'h1ABC); tick();
    chk_wr("basic_p3", 322, 'h1ABC); tick();
    chk_done("basic_end"); tick();
    chk("basic_done_clr", 32'(done), 32'd0);
    chk("basic_writes", 32'(writes), 32'd4);

    // Backpressure on the second pixel for 3 cycles
    writes = 0;
    send(1, 1, 2, 2, 'h0123);
    chk_wr("bp_p0", 161, 'h0123); tick();
    wr_ready = 1'b0;
    chk_wr("bp_s0", 162, 'h0123); tick();
    chk_wr("bp_s1", 162, 'h0123); tick();
    chk_wr("bp_s2", 162, 'h0123); tick();
    wr_ready = 1'b1;
    chk_wr("bp_p1", 162, 'h0123); tick();
    chk_wr("bp_p2", 321, 'h0123); tick();
    chk_wr("bp_p3", 322, 'h0123); tick();
    chk_done("bp_end"); tick();
    chk("bp_writes", 32'(writes), 32'd4);

    // Clipping at the bottom-right corner
    writes = 0;
    send(158, 119, 4, 2, 'h0555);
    chk_wr("clip_p0", 19198, 'h0555); tick();
    chk_wr("clip_p1", 19199, 'h0555); tick();
    for (int i = 2; i < 8; i++) begin
      chk($sformatf("clip_off%0d_en", i), 32'(wr_en), 32'd0);
      chk($sformatf("clip_off%0d_busy", i), 32'(busy), 32'd1);
      tick();
    end
    chk_done("clip_end"); tick();
    chk("clip_writes", 32'(writes), 32'd2);

    // Zero-size command
    writes = 0;
    send(3, 3, 0, 5, 'h0777);
    chk_done("zero_end"); tick();
    chk("zero_done_clr", 32'(done), 32'd0);
    chk("zero_ready", 32'(cmd_ready), 32'd1);
    chk("zero_writes", 32'(writes), 32'd0);

    // Second command held while a 3x3 fill runs
    writes = 0;
    send(0, 0, 3, 3, 'h0AAA);
    cmd_x = 8'd10; cmd_y = 8'd2; cmd_w = 8'd1; cmd_h = 8'd1; cmd_data = 13'h0BBB;
    cmd_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk_wr($sformatf("busy_p%0d", i), (i / 3) * 160 + (i % 3), 'h0AAA);
      chk($sformatf("busy_p%0d_rdy", i), 32'(cmd_ready), 32'd0);
      tick();
    end
    chk_done("busy_end");
    tick();
    cmd_valid = 1'b0;
    chk("busy_second_done", 32'(done), 32'd0);
    chk_wr("busy_second", 330, 'h0BBB); tick();
    chk_done("busy_second_end"); tick();
    chk("busy_writes", 32'(writes), 32'd10);

    // Reset after two writes of a 4x4 fill
    send(0, 0, 4, 4, 'h0CCC);
    chk_wr("rf_p0", 0, 'h0CCC); tick();
    chk_wr("rf_p1", 1, 'h0CCC); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rf_wren", 32'(wr_en), 32'd0);
    chk("rf_busy", 32'(busy), 32'd0);
    chk("rf_ready", 32'(cmd_ready), 32'd1);
    chk("rf_done", 32'(done), 32'd0);
    tick();
    chk("rf_done_after", 32'(done), 32'd0);
    chk("rf_wren_after", 32'(wr_en), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
